// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter.
package serial_adder_pkg;

    // Controller states; encoding is fixed so debug probes read consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Counter must hold values 0..width, so width+1 distinct codes.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/fulladder_cell.sv
// Combinational full adder built from two half adders; the two partial
// carries can never both be set, so a plain OR merges them.
module fulladder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    halfadder u_ha0 (
        .a (x),
        .b (y),
        .s (s0),
        .c (c0)
    );

    halfadder u_ha1 (
        .a (s0),
        .b (ci),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// Single-bit half adder: sum and carry of two inputs.
module halfadder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured through a valid/ready
// handshake, summed LSB-first one bit per clock through a single full-adder
// cell with a registered carry, and returned through a second handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   SHIFT | one full-adder step per cycle, WIDTH cycles in total
//   DONE  | result presented on sum/cout with out_valid, waiting out_ready
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] a_sr_d;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] b_sr_d;
    logic [WIDTH-1:0] sum_sr_q;
    logic [WIDTH-1:0] sum_sr_d;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic             carry_d;
    logic             cout_q;
    logic             cout_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             fa_s;
    logic             fa_co;

    // The only arithmetic in the block: one full adder on the operand LSBs.
    fulladder_cell u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            count_q  <= count_d;
        end
    end

    // Next-state and datapath update; operands are only sampled on accept,
    // so anything on a/b while idle-and-invalid never reaches the registers.
    // The result registers load only on the last SHIFT step so sum/cout stay
    // stable from DONE until the next result is ready.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d                = fa_co;
                sum_sr_d               = sum_sr_q >> 1;
                sum_sr_d[WIDTH-1]      = fa_s;
                a_sr_d                 = a_sr_q >> 1;
                b_sr_d                 = b_sr_q >> 1;
                count_d                = count_q + CW'(1);
                if (count_q == LAST) begin
                    sum_d   = sum_sr_d;
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (WIDTH 8, 4, 1) share one clock
// and reset. Drivers push the arithmetic result a+b+cin into a per-instance
// queue at the accept edge; a negedge monitor pops and compares whenever an
// output handshake is about to happen.
module tb_serial_adder;

    localparam int WD [3] = '{8, 4, 1};

    logic        clk;
    logic        rst_n;
    logic        in_valid    [3];
    logic        in_ready_v  [3];
    logic [31:0] a_v         [3];
    logic [31:0] b_v         [3];
    logic        cin_v       [3];
    logic        out_valid_v [3];
    logic        out_ready   [3];
    logic        cout_v      [3];
    logic        busy_v      [3];
    logic [7:0]  sum8;
    logic [3:0]  sum4;
    logic [0:0]  sum1;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready[0]),
        .sum(sum8), .cout(cout_v[0]), .busy(busy_v[0])
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .cin(cin_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready[1]),
        .sum(sum4), .cout(cout_v[1]), .busy(busy_v[1])
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2][0:0]), .b(b_v[2][0:0]), .cin(cin_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready[2]),
        .sum(sum1), .cout(cout_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] get_sum(input int idx);
        case (idx)
            0:       return 32'(sum8);
            1:       return 32'(sum4);
            default: return 32'(sum1);
        endcase
    endfunction

    // Reference: plain integer addition of the masked operands.
    function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return ({1'b0, a} & m) + ({1'b0, b} & m) + {32'd0, c};
    endfunction

    function automatic void qpush(input int idx, input logic [32:0] v);
        case (idx)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [32:0] qpop(input int idx);
        case (idx)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, expected event did not occur", name);
    endtask

    // Scoreboard monitor: compare {cout,sum} on every output handshake.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n && out_valid_v[i] && out_ready[i]) begin
                if (qsize(i) == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result dut%0d: got 0x%0h, expected no result",
                             i, get_sum(i));
                end else begin
                    check($sformatf("result_w%0d", WD[i]),
                          {1'b0, get_sum(i)} | ({32'd0, cout_v[i]} << WD[i]),
                          qpop(i));
                end
            end
        end
    end

    // Present one operand set and wait for it to be accepted.
    // Called and returns at #1 after a rising edge.
    task automatic send(input int idx, input logic [31:0] a, input logic [31:0] b, input logic c);
        int k;
        k = 0;
        a_v[idx]      = a;
        b_v[idx]      = b;
        cin_v[idx]    = c;
        in_valid[idx] = 1'b1;
        while (!in_ready_v[idx] && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready_v[idx]) begin
            fail_now("send_wait_in_ready");
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        qpush(idx, model(WD[idx], a, b, c));
        in_valid[idx] = 1'b0;
        a_v[idx]      = $urandom;
        b_v[idx]      = $urandom;
    endtask

    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (!out_valid_v[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_v[idx]) fail_now("wait_out_valid");
    endtask

    task automatic drain(input int idx);
        int k;
        k = 0;
        while (qsize(idx) != 0 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (qsize(idx) != 0) fail_now("drain");
    endtask

    // Cycle-level driver with random gaps and random out_ready stalls.
    // exh=1 walks every {cin,b,a} combination in order.
    task automatic run_ops(input int idx, input int nops, input bit exh);
        int          sent;
        int          cyc;
        int          w;
        bit          acc;
        logic [31:0] m;
        sent = 0;
        cyc  = 0;
        w    = WD[idx];
        m    = 32'((33'd1 << w) - 33'd1);
        while ((sent < nops || qsize(idx) != 0) && cyc < nops * 20 + 200) begin
            acc = in_valid[idx] && in_ready_v[idx];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                qpush(idx, model(w, a_v[idx], b_v[idx], cin_v[idx]));
                sent++;
                in_valid[idx] = 1'b0;
                a_v[idx]      = $urandom;
                b_v[idx]      = $urandom;
            end
            if (!in_valid[idx] && sent < nops && $urandom_range(0, 3) != 0) begin
                if (exh) begin
                    a_v[idx]   = 32'(sent) & m;
                    b_v[idx]   = (32'(sent) >> w) & m;
                    cin_v[idx] = 1'((sent >> (2 * w)) & 1);
                end else begin
                    a_v[idx]   = $urandom;
                    b_v[idx]   = $urandom;
                    cin_v[idx] = 1'($urandom_range(0, 1));
                end
                in_valid[idx] = 1'b1;
            end
            out_ready[idx] = ($urandom_range(0, 2) != 0);
        end
        out_ready[idx] = 1'b1;
        check($sformatf("ops_accepted_w%0d", w), 33'(sent), 33'(nops));
        check($sformatf("queue_empty_w%0d", w), 33'(qsize(idx)), 33'd0);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            a_v[i]       = $urandom;
            b_v[i]       = $urandom;
            cin_v[i]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state on every instance.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready_%0d", i),  33'(in_ready_v[i]), 33'd1);
            check($sformatf("rst_out_valid_%0d", i), 33'(out_valid_v[i]), 33'd0);
            check($sformatf("rst_busy_%0d", i),      33'(busy_v[i]), 33'd0);
            check($sformatf("rst_sum_cout_%0d", i),
                  {1'b0, get_sum(i)} | {32'd0, cout_v[i]}, 33'd0);
        end

        // Zero operands, latency of exactly WIDTH cycles, in_ready back after handshake.
        send(0, 32'h00, 32'h00, 1'b0);
        check("busy_in_shift", 33'(busy_v[0]), 33'd1);
        check("in_ready_in_shift", 33'(in_ready_v[0]), 33'd0);
        wait_valid(0, lat);
        check("latency_w8", 33'(lat), 33'd8);
        @(posedge clk); #1;
        check("in_ready_after_hs", 33'(in_ready_v[0]), 33'd1);
        check("out_valid_after_hs", 33'(out_valid_v[0]), 33'd0);

        // Carry-propagating cases.
        send(0, 32'hFF, 32'h01, 1'b0);
        send(0, 32'hA5, 32'h5A, 1'b1);
        send(0, 32'hFF, 32'hFF, 1'b1);
        drain(0);

        // Backpressure: result held, in_ready low, stray in_valid ignored.
        out_ready[0] = 1'b0;
        send(0, 32'h7F, 32'h01, 1'b0);
        wait_valid(0, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", 33'(sum8), 33'h80);
            check("bp_cout", 33'(cout_v[0]), 33'd0);
            check("bp_in_ready", 33'(in_ready_v[0]), 33'd0);
            check("bp_out_valid", 33'(out_valid_v[0]), 33'd1);
            if (i == 1) begin
                a_v[0]      = 32'h11;
                b_v[0]      = 32'h22;
                in_valid[0] = 1'b1;
            end
            if (i == 3) in_valid[0] = 1'b0;
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 33'(in_ready_v[0]), 33'd1);
        check("bp_out_valid_after", 33'(out_valid_v[0]), 33'd0);
        check("bp_sum_kept", 33'(sum8), 33'h80);
        repeat (12) @(posedge clk);
        #1;
        check("bp_no_extra_op", 33'(busy_v[0]), 33'd0);

        // Reset during the third SHIFT cycle aborts the operation.
        send(0, 32'h55, 32'h0F, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete();
        check("abort_in_ready", 33'(in_ready_v[0]), 33'd1);
        check("abort_out_valid", 33'(out_valid_v[0]), 33'd0);
        check("abort_busy", 33'(busy_v[0]), 33'd0);
        check("abort_sum", 33'(sum8), 33'd0);
        repeat (10) @(posedge clk);
        #1;
        send(0, 32'h12, 32'h34, 1'b0);
        drain(0);
        check("post_abort_sum", 33'(sum8), 33'h46);

        // Random operands with stalls on the 8-bit instance.
        run_ops(0, 60, 1'b0);

        // Exhaustive 4-bit.
        run_ops(1, 512, 1'b1);

        // 1-bit: SHIFT lasts one cycle.
        send(2, 32'd1, 32'd1, 1'b1);
        wait_valid(2, lat);
        check("latency_w1", 33'(lat), 33'd1);
        check("w1_sum_cout", {32'd0, cout_v[2]} << 1 | 33'(sum1), 33'd3);
        drain(2);
        run_ops(2, 8, 1'b1);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. Takes two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Adds them LSB-first, one bit per clock, through a full-adder cell built from two halfadder instances plus a registered carry.
- Returns the WIDTH-bit sum and carry-out through a second valid/ready handshake.
- Sits directly downstream of the halfadder cell as its first sequential consumer. Trades area for latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b, cin valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a+b+cin modulo 2^WIDTH.
- cout  output  1  carry-out of the addition.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Clock and reset:
  - One clock (clk). Reset rst_n is synchronous and active-low.
  - All registers change only on rising clk.
- Reset (rst_n low at an edge):
  - state=IDLE.
  - a_sr, b_sr, sum_sr, carry, count cleared to 0.
  - sum=0, cout=0, out_valid=0, busy=0.
  - in_ready is a decode of state, so it reads 1 after the reset edge.
  - A reset in any state aborts the operation immediately. No partial result is ever presented.
- State machine (2-bit encoding):
  - IDLE:
    - in_ready=1.
    - On in_valid&&in_ready: a_sr<=a, b_sr<=b, carry<=cin, count<=0, go to SHIFT.
  - SHIFT:
    - in_ready=0. in_valid is ignored.
    - Each cycle, the full-adder cell computes s=a_sr[0]^b_sr[0]^carry and c=(a_sr[0]&b_sr[0])|((a_sr[0]^b_sr[0])&carry).
    - Register updates: carry<=c; sum_sr<={s, sum_sr[WIDTH-1:1]}; a_sr, b_sr shift right by 1 with zero fill; count<=count+1.
    - When count==WIDTH-1 this cycle, go to DONE.
  - DONE:
    - out_valid=1. sum=sum_sr, cout=carry, both held stable while out_valid is high.
    - in_ready=0.
    - On out_valid&&out_ready, go to IDLE and clear out_valid. sum and cout keep their last value until the next DONE.
- Latency:
  - Accept edge = edge 0. out_valid is first high after edge WIDTH, i.e. exactly WIDTH cycles after acceptance.
  - With out_ready held high, the output handshake occurs at edge WIDTH+1 and in_ready returns at that edge.
  - Throughput is one operation per WIDTH+2 cycles.
- Width rules:
  - count width is clog2(WIDTH+1). For WIDTH=1, SHIFT lasts exactly one cycle.
  - Overflow is never flagged separately; it is reported only via cout.
- Boundary cases:
  - a=b=all-ones with cin=1 gives sum=all-ones, cout=1.
  - in_valid raised in SHIFT/DONE is not consumed. The source must hold it until in_ready.
  - out_ready high outside DONE has no effect.
  - X on a/b while in_valid=0 must not propagate into state.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding constants: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - a count-width helper function.
- Sub-module fulladder_cell:
  - Two halfadder instances plus an OR on the carries. Inputs x, y, ci; outputs s, co.
  - Purely combinational, instantiated once inside serial_adder.

Test Plan:
1. WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0; out_valid rises exactly 8 cycles after the accept edge.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
3. Backpressure: a=0x7F, b=0x01, out_ready low for 5 cycles in DONE -> sum=0x80, cout=0 held stable; in_ready=0 throughout; a second in_valid pulse is ignored; after handshake, in_ready=1 next cycle.
4. Reset: rst_n low for one edge on the 3rd SHIFT cycle -> next cycle state IDLE, out_valid=0, sum=0, busy=0. Follow-up a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
5. WIDTH=4 exhaustive: all 512 {a,b,cin} combinations with random out_ready stalls -> {cout,sum} equals a+b+cin every time, and no result is dropped or duplicated.
6. WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, with out_valid one cycle after accept.
